// File: rtl/uart_proto_pkg.sv
// Shared host-protocol definitions for the UART job framer: message types,
// CRC-32 constants and step function, FSM state and response enums.
package uart_proto_pkg;

    localparam logic [7:0]  MSG_INFO     = 8'd0;
    localparam logic [7:0]  MSG_INVALID  = 8'd1;
    localparam logic [7:0]  MSG_PUSH_JOB = 8'd2;
    localparam logic [7:0]  MSG_NONCE    = 8'd3;
    localparam logic [7:0]  MSG_ACK      = 8'd4;
    localparam logic [7:0]  MSG_RESEND   = 8'd5;
    localparam int          HDR_LEN      = 4;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

    typedef enum logic [1:0] {RX_IDLE, RX_READ, RX_DISCARD, RX_PARSE} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [2:0] {RESP_PONG, RESP_INVALID, RESP_ACK, RESP_RESEND, RESP_INFO} resp_kind_t;

    function automatic logic [7:0] pong_byte();
        return 8'h00;
    endfunction

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/uart_job_framer_if.sv
// Byte-stream link between the framer (master) and the UART byte core (slave).
interface uart_job_framer_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_byte;

    modport master (input rx_valid, rx_byte, tx_busy, output tx_start, tx_byte);
    modport slave  (output rx_valid, rx_byte, tx_busy, input tx_start, tx_byte);
endinterface

// File: rtl/crc32_byte.sv
// One-byte-per-cycle CRC-32 register; start restarts from the init value.
module crc32_byte
    import uart_proto_pkg::*;
(
    input  logic        comm_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge comm_clk) begin
        if (!rst_n)     crc <= CRC_INIT;
        else if (start) crc <= crc32_step(CRC_INIT, data);
        else if (en)    crc <= crc32_step(crc, data);
    end

endmodule

// File: rtl/nonce_fifo.sv
// Synchronous FIFO for golden nonces; DEPTH must be a power of 2.
module nonce_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             comm_clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge comm_clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge comm_clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_job_framer.sv
// Host protocol engine: deframes/CRC-checks host packets, issues jobs, frames replies and nonces.
// Define NONCE_CHAN_TAG_EN to add a channel-index byte to NONCE frames (L=13).
module uart_job_framer
    import uart_proto_pkg::*;
#(
    parameter int          N_CHAN         = 4,
    parameter int          JOB_BYTES      = 52,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TIMEOUT_CYCLES = 20000,
    parameter logic [63:0] SYS_INFO       = 64'hDEADBEEF13370D13
) (
    input  logic                   comm_clk,
    input  logic                   rst_n,
    uart_job_framer_if.master      uart,
    input  logic [N_CHAN-1:0]      nonce_valid,
    input  logic [32*N_CHAN-1:0]   nonce_data,
    output logic [8*JOB_BYTES-1:0] job_data,
    output logic                   new_work,
    output logic                   crc_err,
    output logic                   nonce_ovf
);

    localparam int         CH_W    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int         TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] MAX_LEN = 8'(JOB_BYTES + 8);
    localparam logic [7:0] PAY_END = 8'(HDR_LEN + JOB_BYTES);
`ifdef NONCE_CHAN_TAG_EN
    localparam int         ENTRY_W   = 32 + CH_W;
    localparam logic [7:0] NONCE_LEN = 8'd13;
`else
    localparam int         ENTRY_W   = 32;
    localparam logic [7:0] NONCE_LEN = 8'd12;
`endif

    rx_state_t rx_state, rx_next;
    tx_state_t tx_state, tx_next;
    resp_kind_t resp_kind, set_kind;
    logic [7:0]  rx_len, rx_cnt, rx_type;
    logic [8*JOB_BYTES-1:0] job_shift;
    logic [TO_W-1:0] idle_cnt;
    logic [31:0] rx_crc, tx_crc;
    logic timeout, rx_crc_start, rx_crc_en, set_resp, job_load, crc_fail, job_upd;
    logic resp_pending, resp_taken;

    crc32_byte u_rx_crc (.comm_clk, .rst_n, .start(rx_crc_start), .en(rx_crc_en),
                         .data(uart.rx_byte), .crc(rx_crc));

    assign timeout = (rx_state == RX_READ || rx_state == RX_DISCARD) && !uart.rx_valid &&
                     (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge comm_clk) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next      = rx_state;
        set_resp     = 1'b0;
        set_kind     = RESP_INVALID;
        job_load     = 1'b0;
        crc_fail     = 1'b0;
        rx_crc_start = 1'b0;
        rx_crc_en    = 1'b0;
        case (rx_state)
            RX_IDLE: if (uart.rx_valid) begin
                if (uart.rx_byte == 8'd0) begin
                    set_resp = 1'b1;
                    set_kind = RESP_PONG;
                end else if (uart.rx_byte < 8'd8) begin
                    set_resp = 1'b1;
                end else if (uart.rx_byte > MAX_LEN) begin
                    rx_next = RX_DISCARD;
                end else begin
                    rx_next      = RX_READ;
                    rx_crc_start = 1'b1;
                end
            end
            RX_READ: if (timeout) begin
                set_resp = 1'b1;
                rx_next  = RX_IDLE;
            end else if (uart.rx_valid) begin
                rx_crc_en = 1'b1;
                if (rx_cnt + 8'd1 == rx_len) rx_next = RX_PARSE;
            end
            RX_DISCARD: if (timeout) begin
                set_resp = 1'b1;
                rx_next  = RX_IDLE;
            end
            RX_PARSE: if (!resp_pending) begin
                rx_next  = RX_IDLE;
                set_resp = 1'b1;
                if (rx_crc != 32'd0) begin
                    set_kind = RESP_RESEND;
                    crc_fail = 1'b1;
                end else if (rx_type == MSG_INFO && rx_len == 8'd8) begin
                    set_kind = RESP_INFO;
                end else if (rx_type == MSG_PUSH_JOB && rx_len == MAX_LEN) begin
                    set_kind = RESP_ACK;
                    job_load = 1'b1;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Payload bytes shift in so the first one ends up in the MSB of job_data.
    always_ff @(posedge comm_clk) begin
        if (!rst_n) begin
            rx_len <= '0; rx_cnt <= '0; rx_type <= '0; job_shift <= '0; idle_cnt <= '0;
            job_data <= '0; job_upd <= 1'b0; new_work <= 1'b0; crc_err <= 1'b0;
            resp_pending <= 1'b0; resp_kind <= RESP_PONG;
        end else begin
            job_upd  <= job_load;
            new_work <= job_upd;
            crc_err  <= crc_fail;
            if (job_load) job_data <= job_shift;
            if (set_resp) begin
                resp_pending <= 1'b1;
                resp_kind    <= set_kind;
            end else if (resp_taken) begin
                resp_pending <= 1'b0;
            end
            if (rx_state == RX_IDLE && uart.rx_valid) begin
                rx_len <= uart.rx_byte;
                rx_cnt <= 8'd1;
            end else if (rx_state == RX_READ && uart.rx_valid) begin
                rx_cnt <= rx_cnt + 8'd1;
                if (rx_cnt == 8'd3) rx_type <= uart.rx_byte;
                if (rx_cnt >= 8'(HDR_LEN) && rx_cnt < PAY_END)
                    job_shift <= {job_shift[8*JOB_BYTES-9:0], uart.rx_byte};
            end
            if (uart.rx_valid || rx_next != rx_state) idle_cnt <= '0;
            else if (rx_state == RX_READ || rx_state == RX_DISCARD) idle_cnt <= idle_cnt + 1'b1;
        end
    end

    logic [N_CHAN-1:0] hold_valid, grant;
    logic [31:0]       hold_data [N_CHAN];
    logic [CH_W-1:0]   rr_ptr, grant_idx, cand;
    logic              grant_any, fifo_full, fifo_empty, fifo_rd;
    logic [ENTRY_W-1:0] fifo_wr_data, fifo_rd_data;

    // Round-robin search starting at rr_ptr; a full FIFO blocks every grant.
    always_comb begin
        grant     = '0;
        grant_idx = rr_ptr;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            cand = CH_W'((int'(rr_ptr) + k) % N_CHAN);
            if (!grant_any && !fifo_full && hold_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = grant_any;
    end

    always_ff @(posedge comm_clk) begin
        for (int c = 0; c < N_CHAN; c++)
            if (nonce_valid[c] && (!hold_valid[c] || grant[c])) hold_data[c] <= nonce_data[32*c +: 32];
    end

    always_ff @(posedge comm_clk) begin
        if (!rst_n) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
            nonce_ovf  <= 1'b0;
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (nonce_valid[c] && (!hold_valid[c] || grant[c])) hold_valid[c] <= 1'b1;
                else if (grant[c]) hold_valid[c] <= 1'b0;
                if (nonce_valid[c] && hold_valid[c] && !grant[c]) nonce_ovf <= 1'b1;
            end
            if (grant_any) rr_ptr <= (grant_idx == CH_W'(N_CHAN - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef NONCE_CHAN_TAG_EN
    assign fifo_wr_data = {grant_idx, hold_data[grant_idx]};
`else
    assign fifo_wr_data = hold_data[grant_idx];
`endif

    nonce_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .comm_clk, .rst_n, .wr_en(grant_any), .wr_data(fifo_wr_data), .rd_en(fifo_rd),
        .rd_data(fifo_rd_data), .full(fifo_full), .empty(fifo_empty));

    logic [127:0] tx_buf;
    logic [7:0]   tx_len, tx_idx, cur_byte;
    logic [3:0]   buf_sel;
    logic [1:0]   crc_sel;
    logic         tx_nocrc, in_crc, send_ok;

    // Header and payload come from tx_buf (byte 0 at the top); the CRC tail comes from the engine, LSB first.
    assign send_ok  = (tx_state == TX_SEND) && !uart.tx_busy && !uart.tx_start;
    assign in_crc   = !tx_nocrc && (tx_idx >= tx_len - 8'd4);
    assign crc_sel  = 2'(tx_idx - (tx_len - 8'd4));
    assign buf_sel  = 4'd15 - tx_idx[3:0];
    assign cur_byte = in_crc ? tx_crc[{crc_sel, 3'b000} +: 8] : tx_buf[{buf_sel, 3'b000} +: 8];

    crc32_byte u_tx_crc (.comm_clk, .rst_n, .start(send_ok && tx_idx == 8'd0), .en(send_ok && !in_crc),
                         .data(cur_byte), .crc(tx_crc));

    always_ff @(posedge comm_clk) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next    = tx_state;
        resp_taken = 1'b0;
        fifo_rd    = 1'b0;
        case (tx_state)
            TX_IDLE: if (resp_pending) begin
                resp_taken = 1'b1;
                tx_next    = TX_SEND;
            end else if (!fifo_empty) begin
                fifo_rd = 1'b1;
                tx_next = TX_SEND;
            end
            TX_SEND: if (send_ok && tx_idx == tx_len - 8'd1) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge comm_clk) begin
        if (!rst_n) begin
            tx_buf <= '0; tx_len <= '0; tx_idx <= '0; tx_nocrc <= 1'b0;
            uart.tx_start <= 1'b0; uart.tx_byte <= '0;
        end else begin
            uart.tx_start <= send_ok;
            if (send_ok) begin
                uart.tx_byte <= cur_byte;
                tx_idx       <= tx_idx + 8'd1;
            end
            if (resp_taken) begin
                tx_idx   <= '0;
                tx_nocrc <= (resp_kind == RESP_PONG);
                tx_len   <= 8'd8;
                case (resp_kind)
                    RESP_PONG:   begin tx_len <= 8'd1; tx_buf <= {pong_byte(), 120'd0}; end
                    RESP_INFO:   begin tx_len <= 8'd16; tx_buf <= {8'd16, 24'd0, SYS_INFO, 32'd0}; end
                    RESP_ACK:    tx_buf <= {8'd8, 16'd0, MSG_ACK, 96'd0};
                    RESP_RESEND: tx_buf <= {8'd8, 16'd0, MSG_RESEND, 96'd0};
                    default:     tx_buf <= {8'd8, 16'd0, MSG_INVALID, 96'd0};
                endcase
            end else if (fifo_rd) begin
                tx_idx   <= '0;
                tx_nocrc <= 1'b0;
                tx_len   <= NONCE_LEN;
`ifdef NONCE_CHAN_TAG_EN
                tx_buf   <= {NONCE_LEN, 16'd0, MSG_NONCE, 8'(fifo_rd_data[32 +: CH_W]), fifo_rd_data[31:0], 56'd0};
`else
                tx_buf   <= {NONCE_LEN, 16'd0, MSG_NONCE, fifo_rd_data, 64'd0};
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_job_framer.sv
// Directed bench for uart_job_framer: builds expected reply frames from the protocol rules
// and checks every transmitted byte against them.
`timescale 1ns/1ps
module tb_uart_job_framer;

    localparam int N_CHAN         = 4;
    localparam int JOB_BYTES      = 52;
    localparam int TIMEOUT_CYCLES = 20000;

    typedef logic [7:0] byte_q_t [$];

    logic comm_clk = 1'b0;
    logic rst_n    = 1'b0;
    logic [N_CHAN-1:0]      nonce_valid;
    logic [32*N_CHAN-1:0]   nonce_data;
    logic [8*JOB_BYTES-1:0] job_data;
    logic new_work, crc_err, nonce_ovf;

    uart_job_framer_if uif();

    uart_job_framer #(
        .N_CHAN(N_CHAN), .JOB_BYTES(JOB_BYTES), .FIFO_DEPTH(8),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SYS_INFO(64'hDEADBEEF13370D13)
    ) dut (
        .comm_clk(comm_clk), .rst_n(rst_n), .uart(uif),
        .nonce_valid(nonce_valid), .nonce_data(nonce_data), .job_data(job_data),
        .new_work(new_work), .crc_err(crc_err), .nonce_ovf(nonce_ovf)
    );

    always #5 comm_clk = ~comm_clk;

    int checks = 0;
    int fails  = 0;
    int busy_cnt = 0;
    int new_work_cnt = 0;
    int crc_err_cnt  = 0;
    byte_q_t exp_q;

    // Bit-serial reflected CRC-32, init all ones, no final xor.
    function automatic logic [31:0] model_crc(input byte_q_t bytes);
        logic [31:0] r;
        logic fb;
        r = 32'hFFFFFFFF;
        foreach (bytes[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ bytes[i][b];
                r  = r >> 1;
                if (fb) r = r ^ 32'hEDB88320;
            end
        end
        return r;
    endfunction

    function automatic byte_q_t build_frame(input logic [7:0] typ, input byte_q_t payload);
        byte_q_t f;
        logic [31:0] c;
        f.push_back(8'(payload.size() + 8));
        f.push_back(8'h00);
        f.push_back(8'h00);
        f.push_back(typ);
        foreach (payload[i]) f.push_back(payload[i]);
        c = model_crc(f);
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input byte_q_t bytes);
        foreach (bytes[i]) begin
            @(negedge comm_clk);
            uif.rx_valid = 1'b1;
            uif.rx_byte  = bytes[i];
            @(negedge comm_clk);
            uif.rx_valid = 1'b0;
        end
    endtask

    task automatic expectFrame(input byte_q_t f);
        foreach (f[i]) exp_q.push_back(f[i]);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge comm_clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_drain: %0d bytes still owed after %0d cycles, expected 0", name, exp_q.size(), n);
            exp_q.delete();
        end
        repeat (40) @(negedge comm_clk);
    endtask

    // UART transmitter model plus the per-byte compare against the expected stream.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge comm_clk);
            if (rst_n) begin
                if (new_work) new_work_cnt++;
                if (crc_err)  crc_err_cnt++;
                if (uif.tx_start) begin
                    checks++;
                    if (uif.tx_busy) begin
                        fails++;
                        $display("[TB] FAIL tx_start_while_busy: got busy=1, expected 0");
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL unexpected_tx: got %02h, expected no byte", uif.tx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        if (uif.tx_byte !== e) begin
                            fails++;
                            $display("[TB] FAIL tx_byte: got %02h, expected %02h", uif.tx_byte, e);
                        end
                    end
                end
            end
            if (uif.tx_start) busy_cnt = 4;
            else if (busy_cnt > 0) busy_cnt--;
            uif.tx_busy = (busy_cnt != 0);
        end
    endtask

    initial begin
        byte_q_t none, ping, q, info_rep, payload, bad_payload, req, bad_req;
        logic [8*JOB_BYTES-1:0] exp_job, bad_job;
        logic [95:0] head;
        int n;

        uif.rx_valid = 1'b0;
        uif.rx_byte  = 8'h00;
        uif.tx_busy  = 1'b0;
        nonce_valid  = '0;
        nonce_data   = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge comm_clk);
        checkOutput("reset_tx_start", uif.tx_start, 0);
        checkOutput("reset_tx_byte", uif.tx_byte, 0);
        checkOutput("reset_job_data", job_data, 0);
        checkOutput("reset_new_work", new_work, 0);
        checkOutput("reset_crc_err", crc_err, 0);
        checkOutput("reset_nonce_ovf", nonce_ovf, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge comm_clk);

        // Pin the model: CRC check string, literal INFO reply head, zero residue.
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
        checkOutput("model_crc_check", model_crc(q), 32'h340BC6D9);
        q.delete();
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h13, 8'h37, 8'h0D, 8'h13};
        info_rep = build_frame(8'd0, q);
        head = '0;
        for (int i = 0; i < 12; i++) head = {head[87:0], info_rep[i]};
        checkOutput("model_info_head", head, 96'h10000000DEADBEEF13370D13);
        checkOutput("model_info_residue", model_crc(info_rep), 0);
        checkOutput("model_info_len", info_rep.size(), 16);

        ping.push_back(8'h00);
        expectFrame(ping);
        applyStimulus(ping);
        waitDrain("ping", 2000);

        q.delete();
        q.push_back(8'h05);
        expectFrame(build_frame(8'd1, none));
        applyStimulus(q);
        waitDrain("short_invalid", 2000);

        expectFrame(info_rep);
        applyStimulus(build_frame(8'd0, none));
        waitDrain("info", 2000);

        exp_job = '0;
        bad_job = '0;
        for (int i = 0; i < JOB_BYTES; i++) begin
            payload.push_back(8'(i));
            bad_payload.push_back(8'(8'h80 + i));
            exp_job = {exp_job[8*JOB_BYTES-9:0], 8'(i)};
        end
        req = build_frame(8'd2, payload);
        new_work_cnt = 0;
        expectFrame(build_frame(8'd4, none));
        applyStimulus(req);
        waitDrain("push_job", 3000);
        checkOutput("push_len", req.size(), 60);
        checkOutput("job_data", job_data, exp_job);
        checkOutput("job_data_msb", job_data[415:408], 8'h00);
        checkOutput("job_data_lsb", job_data[7:0], 8'h33);
        checkOutput("new_work_pulses", new_work_cnt, 1);

        bad_req = build_frame(8'd2, bad_payload);
        bad_req[bad_req.size()-1] = bad_req[bad_req.size()-1] ^ 8'hFF;
        crc_err_cnt = 0;
        expectFrame(build_frame(8'd5, none));
        applyStimulus(bad_req);
        waitDrain("bad_crc", 3000);
        checkOutput("crc_err_pulses", crc_err_cnt, 1);
        checkOutput("job_data_kept", job_data, exp_job);
        checkOutput("new_work_after_bad", new_work_cnt, 1);

        for (int c = 0; c < N_CHAN; c++) begin
            q.delete();
`ifdef NONCE_CHAN_TAG_EN
            q.push_back(8'(c));
`endif
            for (int b = 0; b < 4; b++) q.push_back(8'(8'h11 * (c + 1)));
            expectFrame(build_frame(8'd3, q));
        end
        @(negedge comm_clk);
        nonce_valid = '1;
        nonce_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        @(negedge comm_clk);
        nonce_valid = '0;
        waitDrain("nonces", 3000);
        checkOutput("nonce_ovf", nonce_ovf, 0);

        q.delete();
        q.push_back(8'd60);
        for (int i = 1; i <= 10; i++) q.push_back(8'(i));
        expectFrame(build_frame(8'd1, none));
        applyStimulus(q);
        waitDrain("timeout", TIMEOUT_CYCLES + 3000);
        expectFrame(ping);
        applyStimulus(ping);
        waitDrain("ping_after_timeout", 2000);

        // Reset in the middle of an outgoing INFO reply.
        expectFrame(info_rep);
        applyStimulus(build_frame(8'd0, none));
        n = 0;
        while (exp_q.size() > 12 && n < 2000) begin
            @(negedge comm_clk);
            n++;
        end
        checkOutput("midframe_started", (exp_q.size() <= 12), 1);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge comm_clk);
        checkOutput("midreset_tx_start", uif.tx_start, 0);
        checkOutput("midreset_job_data", job_data, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge comm_clk);
        expectFrame(ping);
        applyStimulus(ping);
        waitDrain("ping_after_reset", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
